// File: rtl/light_pkg.sv
// ============================================================================
// Module      : light_pkg
// Description : Shared types, seven-segment constants and the elaboration-time
//               seconds-load helper for the traffic-light status display.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package light_pkg;

  // Decoded display phase; FLT covers any multi-enable combination
  typedef enum logic [2:0] {
    OFF    = 3'd0,
    GREEN  = 3'd1,
    YELLOW = 3'd2,
    RED    = 3'd3,
    FLT    = 3'd4
  } phase_e;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // ceil(cyc/hz) saturated at 99, returned as {tens, ones} BCD
  function automatic logic [7:0] sec_bcd(input int unsigned cyc, input int unsigned hz);
    int unsigned s;
    if (hz == 0) begin
      s = 99;
    end else begin
      s = (cyc + hz - 1) / hz;
    end
    if (s > 99) begin
      s = 99;
    end
    return {4'(s / 10), 4'(s % 10)};
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_decoder.sv
// ============================================================================
// Module      : seg7_decoder
// Description : Combinational BCD digit to active-low seven-segment pattern
//               {g,f,e,d,c,b,a}. Non-decimal codes render blank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_decoder
  import light_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  // Digit lookup
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = 7'h40;
      4'd1:    o_seg = 7'h79;
      4'd2:    o_seg = 7'h24;
      4'd3:    o_seg = 7'h30;
      4'd4:    o_seg = 7'h19;
      4'd5:    o_seg = 7'h12;
      4'd6:    o_seg = 7'h02;
      4'd7:    o_seg = 7'h78;
      4'd8:    o_seg = 7'h00;
      4'd9:    o_seg = 7'h10;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/light_status_display.sv
// ============================================================================
// Module      : light_status_display
// Description : Lamp drivers, two-digit seconds-remaining countdown and
//               illegal-enable flag for the traffic-light controller outputs.
//               Optional macro LIGHT_DISPLAY_BLINK_EN flashes the yellow lamp.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module light_status_display
  import light_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned GREEN_CYC  = 180_000_000,
  parameter int unsigned YELLOW_CYC = 60_000_000,
  parameter int unsigned RED_CYC    = 70_000_000,
  parameter int unsigned BLINK_CYC  = 12_500_000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       GREEN_EN,
  input  logic       YELLOW_EN,
  input  logic       RED_EN,
  output logic       LED_G,
  output logic       LED_Y,
  output logic       LED_R,
  output logic [6:0] HEX_TENS,
  output logic [6:0] HEX_ONES,
  output logic [1:0] PHASE,
  output logic       FAULT
);

  localparam int unsigned c_PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned c_BLK_W = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(CLK_HZ - 1);
  localparam logic [c_BLK_W-1:0] c_BLK_MAX = c_BLK_W'(BLINK_CYC - 1);
  localparam logic [7:0] c_LOAD_G = sec_bcd(GREEN_CYC, CLK_HZ);
  localparam logic [7:0] c_LOAD_Y = sec_bcd(YELLOW_CYC, CLK_HZ);
  localparam logic [7:0] c_LOAD_R = sec_bcd(RED_CYC, CLK_HZ);

  logic [2:0]         r_en_q;
  phase_e             r_state;
  phase_e             w_next;
  logic [c_PRE_W-1:0] r_pre,  w_pre_nxt;
  logic [c_BLK_W-1:0] r_bcnt, w_bcnt_nxt;
  logic [7:0]         r_sec,  w_sec_nxt;
  logic               r_blink, w_blink_nxt;
  logic               w_entry;
  logic [6:0]         w_dec_t, w_dec_o;
  logic               w_led_g, w_led_y, w_led_r, w_fault;
  logic [6:0]         w_hex_t, w_hex_o;
  logic [1:0]         w_phase;

  // Next state is simply the decoded registered enables
  always_comb begin
    w_next = FLT;
    case (r_en_q)
      3'b000:  w_next = OFF;
      3'b001:  w_next = GREEN;
      3'b010:  w_next = YELLOW;
      3'b100:  w_next = RED;
      default: w_next = FLT;
    endcase
  end

  assign w_entry = (w_next != r_state);

  // Prescaler, BCD countdown and blink counter next values
  always_comb begin
    w_pre_nxt   = r_pre;
    w_sec_nxt   = r_sec;
    w_bcnt_nxt  = r_bcnt;
    w_blink_nxt = r_blink;
    if (w_entry) begin
      w_pre_nxt   = '0;
      w_bcnt_nxt  = '0;
      w_blink_nxt = 1'b1;
      case (w_next)
        GREEN:   w_sec_nxt = c_LOAD_G;
        YELLOW:  w_sec_nxt = c_LOAD_Y;
        RED:     w_sec_nxt = c_LOAD_R;
        default: w_sec_nxt = 8'h00;
      endcase
    end else begin
      if (r_bcnt == c_BLK_MAX) begin
        w_bcnt_nxt  = '0;
        w_blink_nxt = ~r_blink;
      end else begin
        w_bcnt_nxt = r_bcnt + 1'b1;
      end
      if (w_next == GREEN || w_next == YELLOW || w_next == RED) begin
        if (r_pre == c_PRE_MAX) begin
          w_pre_nxt = '0;
          // Saturate at 00; otherwise borrow from tens when ones is 0
          if (r_sec == 8'h00) begin
            w_sec_nxt = 8'h00;
          end else if (r_sec[3:0] == 4'd0) begin
            w_sec_nxt = {r_sec[7:4] - 4'd1, 4'd9};
          end else begin
            w_sec_nxt = {r_sec[7:4], r_sec[3:0] - 4'd1};
          end
        end else begin
          w_pre_nxt = r_pre + 1'b1;
        end
      end
    end
  end

  seg7_decoder u_dec_tens (.i_bcd(w_sec_nxt[7:4]), .o_seg(w_dec_t));
  seg7_decoder u_dec_ones (.i_bcd(w_sec_nxt[3:0]), .o_seg(w_dec_o));

  // Lamp, digit and phase values for the upcoming cycle
  always_comb begin
    w_led_g = 1'b0;
    w_led_y = 1'b0;
    w_led_r = 1'b0;
    w_fault = 1'b0;
    w_hex_t = SEG_BLANK;
    w_hex_o = SEG_BLANK;
    w_phase = 2'd0;
    case (w_next)
      GREEN: begin
        w_led_g = 1'b1;
        w_phase = 2'd1;
      end
      YELLOW: begin
`ifdef LIGHT_DISPLAY_BLINK_EN
        w_led_y = w_blink_nxt;
`else
        w_led_y = 1'b1;
`endif
        w_phase = 2'd2;
      end
      RED: begin
        w_led_r = 1'b1;
        w_phase = 2'd3;
      end
      FLT: begin
        w_led_r = w_blink_nxt;
        w_fault = 1'b1;
        w_hex_t = SEG_DASH;
        w_hex_o = SEG_DASH;
      end
      default: ;
    endcase
    if (w_next == GREEN || w_next == YELLOW || w_next == RED) begin
      // Leading tens zero is suppressed; ones always shown
      w_hex_t = (w_sec_nxt[7:4] == 4'd0) ? SEG_BLANK : w_dec_t;
      w_hex_o = w_dec_o;
    end
  end

  // State register plus all registered counters and outputs
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_en_q   <= 3'b000;
      r_state  <= OFF;
      r_pre    <= '0;
      r_sec    <= 8'h00;
      r_bcnt   <= '0;
      r_blink  <= 1'b0;
      LED_G    <= 1'b0;
      LED_Y    <= 1'b0;
      LED_R    <= 1'b0;
      FAULT    <= 1'b0;
      HEX_TENS <= SEG_BLANK;
      HEX_ONES <= SEG_BLANK;
      PHASE    <= 2'd0;
    end else begin
      r_en_q   <= {RED_EN, YELLOW_EN, GREEN_EN};
      r_state  <= w_next;
      r_pre    <= w_pre_nxt;
      r_sec    <= w_sec_nxt;
      r_bcnt   <= w_bcnt_nxt;
      r_blink  <= w_blink_nxt;
      LED_G    <= w_led_g;
      LED_Y    <= w_led_y;
      LED_R    <= w_led_r;
      FAULT    <= w_fault;
      HEX_TENS <= w_hex_t;
      HEX_ONES <= w_hex_o;
      PHASE    <= w_phase;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_light_status_display.sv
// ============================================================================
// Module      : tb_light_status_display
// Description : Directed self-checking bench for light_status_display using
//               CLK_HZ=10, GREEN=36, YELLOW=12, RED=14, BLINK=2 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_light_status_display;

  localparam logic [6:0] S_BLANK = 7'h7F;
  localparam logic [6:0] S_DASH  = 7'h3F;
  localparam logic [6:0] S0 = 7'h40;
  localparam logic [6:0] S1 = 7'h79;
  localparam logic [6:0] S2 = 7'h24;
  localparam logic [6:0] S3 = 7'h30;
  localparam logic [6:0] S4 = 7'h19;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       GREEN_EN, YELLOW_EN, RED_EN;
  logic       LED_G, LED_Y, LED_R, FAULT;
  logic [6:0] HEX_TENS, HEX_ONES;
  logic [1:0] PHASE;

  int n_tests = 0;
  int n_fail  = 0;

  light_status_display #(
    .CLK_HZ(10), .GREEN_CYC(36), .YELLOW_CYC(12), .RED_CYC(14), .BLINK_CYC(2)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .GREEN_EN(GREEN_EN), .YELLOW_EN(YELLOW_EN), .RED_EN(RED_EN),
    .LED_G(LED_G), .LED_Y(LED_Y), .LED_R(LED_R),
    .HEX_TENS(HEX_TENS), .HEX_ONES(HEX_ONES),
    .PHASE(PHASE), .FAULT(FAULT)
  );

  always #5 Clk = ~Clk;

  // Advance n rising edges, landing 1ns after the last one
  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic set_en(input logic g, input logic y, input logic r);
    GREEN_EN = g; YELLOW_EN = y; RED_EN = r;
  endtask

  task automatic test_reset;
    Reset_n = 1'b0;
    set_en(1'b1, 1'b0, 1'b0);
    step(3);
    n_tests++; if ({LED_G, LED_Y, LED_R} !== 3'b000) begin n_fail++; $display("FAIL reset_leds: got %b want 000", {LED_G, LED_Y, LED_R}); end
    n_tests++; if (HEX_TENS !== S_BLANK || HEX_ONES !== S_BLANK) begin n_fail++; $display("FAIL reset_hex: got %h/%h want 7f/7f", HEX_TENS, HEX_ONES); end
    n_tests++; if (PHASE !== 2'd0 || FAULT !== 1'b0) begin n_fail++; $display("FAIL reset_phase_fault: got %0d/%b want 0/0", PHASE, FAULT); end
    Reset_n = 1'b1;
    step(1);
    n_tests++; if (LED_G !== 1'b0) begin n_fail++; $display("FAIL reset_latency1: LED_G got %b want 0", LED_G); end
    step(1);
    n_tests++; if (LED_G !== 1'b1 || PHASE !== 2'd1) begin n_fail++; $display("FAIL reset_release: LED_G/PHASE got %b/%0d want 1/1", LED_G, PHASE); end
  endtask

  // Entered GREEN on the previous edge; ones digit steps 4..0 every 10 cycles
  task automatic test_green_countdown;
    logic [6:0] exp_d [0:4];
    exp_d[0] = S4; exp_d[1] = S3; exp_d[2] = S2; exp_d[3] = S1; exp_d[4] = S0;
    n_tests++; if (HEX_ONES !== S4 || HEX_TENS !== S_BLANK) begin n_fail++; $display("FAIL green_load: got %h/%h want 7f/19", HEX_TENS, HEX_ONES); end
    for (int k = 1; k <= 4; k++) begin
      step(9);
      n_tests++; if (HEX_ONES !== exp_d[k-1]) begin n_fail++; $display("FAIL green_hold_%0d: got %h want %h", k, HEX_ONES, exp_d[k-1]); end
      step(1);
      n_tests++; if (HEX_ONES !== exp_d[k] || HEX_TENS !== S_BLANK) begin n_fail++; $display("FAIL green_step_%0d: got %h/%h want 7f/%h", k, HEX_TENS, HEX_ONES, exp_d[k]); end
    end
    step(15);
    n_tests++; if (HEX_ONES !== S0 || LED_G !== 1'b1) begin n_fail++; $display("FAIL green_sat: got %h/%b want 40/1", HEX_ONES, LED_G); end
  endtask

  task automatic test_sequence;
    set_en(1'b0, 1'b1, 1'b0);
    step(1);
    n_tests++; if (LED_G !== 1'b1 || LED_Y !== 1'b0) begin n_fail++; $display("FAIL seq_y_latency: G/Y got %b/%b want 1/0", LED_G, LED_Y); end
    step(1);
    n_tests++; if (LED_G !== 1'b0 || LED_Y !== 1'b1 || PHASE !== 2'd2) begin n_fail++; $display("FAIL seq_y_entry: G/Y/PH got %b/%b/%0d want 0/1/2", LED_G, LED_Y, PHASE); end
    n_tests++; if (HEX_ONES !== S2 || HEX_TENS !== S_BLANK) begin n_fail++; $display("FAIL seq_y_load: got %h/%h want 7f/24", HEX_TENS, HEX_ONES); end
    step(10);
    n_tests++; if (HEX_ONES !== S1) begin n_fail++; $display("FAIL seq_y_dec: got %h want 79", HEX_ONES); end
    set_en(1'b0, 1'b0, 1'b1);
    step(2);
    n_tests++; if (LED_R !== 1'b1 || LED_Y !== 1'b0 || PHASE !== 2'd3) begin n_fail++; $display("FAIL seq_r_entry: R/Y/PH got %b/%b/%0d want 1/0/3", LED_R, LED_Y, PHASE); end
    n_tests++; if (HEX_ONES !== S2) begin n_fail++; $display("FAIL seq_r_load: got %h want 24", HEX_ONES); end
    step(12);
    n_tests++; if (HEX_ONES !== S1) begin n_fail++; $display("FAIL seq_r_dec: got %h want 79", HEX_ONES); end
    set_en(1'b0, 1'b0, 1'b0);
    step(1);
    set_en(1'b1, 1'b0, 1'b0);
    step(1);
    n_tests++; if ({LED_G, LED_Y, LED_R} !== 3'b000 || PHASE !== 2'd0) begin n_fail++; $display("FAIL seq_off_leds: GYR/PH got %b/%0d want 000/0", {LED_G, LED_Y, LED_R}, PHASE); end
    n_tests++; if (HEX_TENS !== S_BLANK || HEX_ONES !== S_BLANK) begin n_fail++; $display("FAIL seq_off_hex: got %h/%h want 7f/7f", HEX_TENS, HEX_ONES); end
    step(1);
    n_tests++; if (LED_G !== 1'b1 || HEX_ONES !== S4 || PHASE !== 2'd1) begin n_fail++; $display("FAIL seq_g_reload: G/ones/PH got %b/%h/%0d want 1/19/1", LED_G, HEX_ONES, PHASE); end
  endtask

  task automatic test_fault;
    logic exp_r;
    set_en(1'b1, 1'b0, 1'b1);
    step(2);
    for (int i = 0; i < 5; i++) begin
      exp_r = ((i / 2) % 2) == 0;
      n_tests++; if (LED_R !== exp_r || FAULT !== 1'b1 || LED_G !== 1'b0) begin n_fail++; $display("FAIL fault_blink_%0d: R/F/G got %b/%b/%b want %b/1/0", i, LED_R, FAULT, LED_G, exp_r); end
      n_tests++; if (HEX_TENS !== S_DASH || HEX_ONES !== S_DASH) begin n_fail++; $display("FAIL fault_hex_%0d: got %h/%h want 3f/3f", i, HEX_TENS, HEX_ONES); end
      if (i < 4) step(1);
    end
    set_en(1'b1, 1'b0, 1'b0);
    step(1);
    n_tests++; if (LED_R !== 1'b1 || FAULT !== 1'b1) begin n_fail++; $display("FAIL fault_tail: R/F got %b/%b want 1/1", LED_R, FAULT); end
    step(1);
    n_tests++; if (FAULT !== 1'b0 || LED_G !== 1'b1 || LED_R !== 1'b0 || HEX_ONES !== S4) begin n_fail++; $display("FAIL fault_exit: F/G/R/ones got %b/%b/%b/%h want 0/1/0/19", FAULT, LED_G, LED_R, HEX_ONES); end
  endtask

  task automatic test_blink;
    logic exp_y;
    set_en(1'b0, 1'b1, 1'b0);
    step(2);
    for (int i = 0; i < 10; i++) begin
`ifdef LIGHT_DISPLAY_BLINK_EN
      exp_y = ((i / 2) % 2) == 0;
`else
      exp_y = 1'b1;
`endif
      n_tests++; if (LED_Y !== exp_y) begin n_fail++; $display("FAIL blink_y_%0d: got %b want %b", i, LED_Y, exp_y); end
      step(1);
    end
  endtask

  task automatic test_midreset;
    set_en(1'b1, 1'b0, 1'b0);
    step(2);
    step(14);
    n_tests++; if (HEX_ONES !== S3 || LED_G !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: ones/G got %h/%b want 30/1", HEX_ONES, LED_G); end
    Reset_n = 1'b0;
    #1;
    n_tests++; if (LED_G !== 1'b0 || HEX_ONES !== S_BLANK || HEX_TENS !== S_BLANK || PHASE !== 2'd0) begin n_fail++; $display("FAIL midrst_async: G/ones/tens/PH got %b/%h/%h/%0d want 0/7f/7f/0", LED_G, HEX_ONES, HEX_TENS, PHASE); end
    step(2);
    Reset_n = 1'b1;
    step(1);
    n_tests++; if (HEX_ONES !== S_BLANK) begin n_fail++; $display("FAIL midrst_latency: got %h want 7f", HEX_ONES); end
    step(1);
    n_tests++; if (HEX_ONES !== S4 || LED_G !== 1'b1) begin n_fail++; $display("FAIL midrst_reload: ones/G got %h/%b want 19/1", HEX_ONES, LED_G); end
  endtask

  initial begin
    Reset_n = 1'b0;
    set_en(1'b0, 1'b0, 1'b0);
    test_reset;
    test_green_countdown;
    test_sequence;
    test_fault;
    test_blink;
    test_midreset;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
